// File: rtl/led_ctrl_pkg.sv
// rtl/led_ctrl_pkg.sv - shared mode encodings and widths for the LED pattern controller
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_BLINK = 2'd1,
        S_WATER = 2'd2,
        S_BURST = 2'd3
    } mode_e;

    localparam int CNT_W       = 25;
    localparam int BURST_CNT_W = 6;

    // Modes cycle OFF -> BLINK -> WATER -> BURST -> OFF.
    function automatic mode_e next_mode(input mode_e m);
        return mode_e'(2'(m + 2'd1));
    endfunction

endpackage

// File: rtl/led_pattern_ctrl_tick_gen.sv
// rtl/led_pattern_ctrl_tick_gen.sv - pausable, clearable prescaler producing the pattern step tick
module tick_gen
    import led_ctrl_pkg::*;
#(
    parameter logic [CNT_W-1:0] CLK_DIV_MAX = 25'd24_999_999
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic hold,
    input  logic clr,
    output logic tick
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A clear always restarts the period, even while held.
    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (!hold)
            cnt_d = (cnt_q == CLK_DIV_MAX) ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign tick = (cnt_q == CLK_DIV_MAX) && !hold && !clr;

endmodule

// File: rtl/led_pattern_ctrl.sv
// rtl/led_pattern_ctrl.sv - mode-sequenced LED pattern controller (off, blink, running light, burst)
module led_pattern_ctrl
    import led_ctrl_pkg::*;
#(
    parameter logic [CNT_W-1:0] CLK_DIV_MAX = 25'd24_999_999,
    parameter int               LED_W       = 4,
    parameter int               BURST_N     = 3
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             mode_pulse,
    input  logic             pause,
    output logic [LED_W-1:0] led_out,
    output logic [1:0]       mode_cur,
    output logic             tick_out
);

    localparam logic [BURST_CNT_W-1:0] BURST_LAST    = BURST_CNT_W'(4 * BURST_N - 1);
    localparam logic [BURST_CNT_W-1:0] BURST_LIT_END = BURST_CNT_W'(2 * BURST_N);

    logic                   tick;
    mode_e                  mode_q;
    mode_e                  mode_d;
    logic [LED_W-1:0]       led_q;
    logic [BURST_CNT_W-1:0] burst_q;
    logic [BURST_CNT_W-1:0] burst_d;
    logic                   tick_out_q;

    tick_gen #(
        .CLK_DIV_MAX (CLK_DIV_MAX)
    ) u_tick_gen (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .hold      (pause),
        .clr       (mode_pulse),
        .tick      (tick)
    );

    assign mode_d  = next_mode(mode_q);
    assign burst_d = (burst_q == BURST_LAST) ? '0 : burst_q + BURST_CNT_W'(1);

    // Mode entry wins over a coincident tick; tick is already masked by mode_pulse.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mode_q     <= S_OFF;
            led_q      <= '0;
            burst_q    <= '0;
            tick_out_q <= 1'b0;
        end else if (mode_pulse) begin
            mode_q     <= mode_d;
            burst_q    <= '0;
            tick_out_q <= 1'b0;
            led_q      <= (mode_d == S_WATER) ? LED_W'(1) : '0;
        end else begin
            tick_out_q <= tick;
            if (tick) begin
                case (mode_q)
                    S_OFF:   led_q <= '0;
                    S_BLINK: led_q <= ~led_q;
                    S_WATER: led_q <= {led_q[LED_W-2:0], led_q[LED_W-1]};
                    S_BURST: begin
                        burst_q <= burst_d;
                        led_q   <= (burst_d < BURST_LIT_END && burst_d[0]) ? '1 : '0;
                    end
                    default: led_q <= '0;
                endcase
            end
        end
    end

    assign led_out  = led_q;
    assign mode_cur = mode_q;
    assign tick_out = tick_out_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// tb/tb_led_pattern_ctrl.sv - self-checking bench for led_pattern_ctrl against a step-count reference model
module tb_led_pattern_ctrl;

    localparam logic [24:0] DIV     = 25'd4;
    localparam int          LED_W   = 4;
    localparam int          BURST_N = 2;
    localparam int          PERIOD  = 5;

    logic             sys_clk = 1'b0;
    logic             sys_rst_n;
    logic             mode_pulse;
    logic             pause;
    logic [LED_W-1:0] led_out;
    logic [1:0]       mode_cur;
    logic             tick_out;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference: mode, steps taken since entry, unpaused cycles into the current period.
    int m_mode;
    int m_k;
    int m_phase;
    int m_tick;
    int tick_seen;

    led_pattern_ctrl #(
        .CLK_DIV_MAX (DIV),
        .LED_W       (LED_W),
        .BURST_N     (BURST_N)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .mode_pulse (mode_pulse),
        .pause      (pause),
        .led_out    (led_out),
        .mode_cur   (mode_cur),
        .tick_out   (tick_out)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic int exp_led();
        int b;
        case (m_mode)
            1: return (m_k % 2 == 1) ? 'hF : 0;
            2: return 1 << (m_k % LED_W);
            3: begin
                b = m_k % (4 * BURST_N);
                return (b < 2 * BURST_N && b % 2 == 1) ? 'hF : 0;
            end
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_k     = 0;
        m_phase = 0;
        m_tick  = 0;
    endtask

    task automatic cyc(input bit mp, input bit pz);
        mode_pulse = mp;
        pause      = pz;
        @(posedge sys_clk);
        if (mp) begin
            m_mode  = (m_mode + 1) % 4;
            m_k     = 0;
            m_phase = 0;
            m_tick  = 0;
        end else if (pz) begin
            m_tick = 0;
        end else if (m_phase == PERIOD - 1) begin
            m_phase = 0;
            m_k++;
            m_tick = 1;
        end else begin
            m_phase++;
            m_tick = 0;
        end
        #1;
        if (tick_out === 1'b1) tick_seen++;
        chk("led_out", 32'(led_out), 32'(exp_led()));
        chk("mode_cur", 32'(mode_cur), 32'(m_mode));
        chk("tick_out", 32'(tick_out), 32'(m_tick));
    endtask

    initial begin
        bit pz_r;
        mode_pulse = 1'b0;
        pause      = 1'b0;
        sys_rst_n  = 1'b0;
        model_reset();
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_led", 32'(led_out), 32'd0);
        chk("rst_mode", 32'(mode_cur), 32'd0);
        chk("rst_tick", 32'(tick_out), 32'd0);
        sys_rst_n = 1'b1;

        // Idle in OFF: ticks still pulse every period.
        tick_seen = 0;
        repeat (50) cyc(0, 0);
        chk("off_tick_count", 32'(tick_seen), 32'd10);

        // BLINK, then a 12-cycle pause mid-period.
        cyc(1, 0);
        repeat (12) cyc(0, 0);
        repeat (12) cyc(0, 1);
        repeat (15) cyc(0, 0);

        // Mode pulse coincident with the terminal count.
        for (int i = 0; i < PERIOD + 1 && m_phase != PERIOD - 1; i++) cyc(0, 0);
        chk("phase_at_terminal", 32'(m_phase), 32'(PERIOD - 1));
        cyc(1, 0);
        chk("water_entry", 32'(led_out), 32'h1);
        repeat (22) cyc(0, 0);

        // Asynchronous reset mid-WATER, away from the clock edge.
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("arst_led", 32'(led_out), 32'd0);
        chk("arst_mode", 32'(mode_cur), 32'd0);
        chk("arst_tick", 32'(tick_out), 32'd0);
        model_reset();
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;

        // Back-to-back pulses to BURST, then 40 ticks.
        cyc(1, 0);
        cyc(1, 0);
        cyc(1, 0);
        chk("burst_mode", 32'(mode_cur), 32'd3);
        repeat (40 * PERIOD) cyc(0, 0);

        // Randomized pulses and pause bursts, including pulses during pause.
        pz_r = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 14) == 0) pz_r = ~pz_r;
            cyc($urandom_range(0, 24) == 0, pz_r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/led_pattern_ctrl.md
Name: led_pattern_ctrl

Overview:
- Mode-sequenced LED pattern controller for the board LED bank.
- Contains a prescaler that generates the blink tick, plus a 4-state mode FSM advanced by a one-cycle `mode_pulse` from the key debouncer.
- Drives `LED_W` LEDs with one of four patterns: off, blink-all, running light, burst.
- Replaces free-running single-LED toggling with a controlled, pausable sequencer.

Parameters:
- CLK_DIV_MAX, 25'd24_999_999: prescaler terminal count; tick period = CLK_DIV_MAX+1 sys_clk cycles (0.5 s at 50 MHz).
- LED_W, 4: number of LEDs driven; minimum 2.
- BURST_N, 3: flashes per burst group; range 1..15.

Ports:
- sys_clk  input  1  system clock.
- sys_rst_n  input  1  reset: asynchronous, active-low; clock is sys_clk.
- mode_pulse  input  1  single-cycle strobe; advances the mode.
- pause  input  1  level; freezes prescaler and pattern while high.
- led_out  output  LED_W  LED drive, 1 = on.
- mode_cur  output  2  current mode encoding.
- tick_out  output  1  one-cycle pulse, high in the cycle after each pattern step.

Behaviour:
- Reset values: cnt=0, mode_cur=0 (S_OFF), led_out=0, tick_out=0, burst_cnt=0.
- Prescaler:
  - 25-bit cnt counts 0..CLK_DIV_MAX, then wraps to 0.
  - Internal tick = (cnt==CLK_DIV_MAX) && !pause && !mode_pulse.
  - While pause=1, cnt holds its value and no tick is produced.
- Mode FSM:
  - Encodings: S_OFF=0, S_BLINK=1, S_WATER=2, S_BURST=3.
  - mode_pulse advances OFF→BLINK→WATER→BURST→OFF, one step per pulse.
  - Pulses in consecutive cycles each advance one step.
- Mode entry, at the edge where mode_pulse=1:
  - cnt←0, burst_cnt←0, tick_out←0.
  - led_out←entry value of the new mode: S_WATER = {0…0,1}; all other modes = 0.
  - Mode change takes priority over a coincident tick; that tick is discarded.
  - mode_pulse during pause still changes mode and applies the entry values; the block stays frozen afterwards.
- Pattern step on each tick edge, registered in the same edge as cnt wraps to 0:
  - S_OFF: led_out stays 0.
  - S_BLINK: led_out ← ~led_out (all bits toggle together).
  - S_WATER: rotate left by 1; MSB wraps to bit 0; exactly one bit set at all times.
  - S_BURST:
    - burst_cnt ← (burst_cnt+1) mod 4*BURST_N.
    - led_out ← all ones iff next burst_cnt < 2*BURST_N and next burst_cnt is odd; otherwise 0.
    - Gives BURST_N flashes followed by a 2*BURST_N-tick dark gap.
- tick_out is registered and high for exactly one cycle following each tick edge, coincident with the new led_out value.
- Latency: mode_pulse → new mode_cur/led_out is 1 cycle. First step after mode entry occurs CLK_DIV_MAX+1 cycles later, plus any paused cycles.
- Reset mid-operation: immediate return to the reset values; no partial state survives.
- All counters use fixed widths with no overflow: cnt 25 bits, burst_cnt 6 bits.

Decomposition:
- Shared package `led_ctrl_pkg`:
  - State localparams S_OFF/S_BLINK/S_WATER/S_BURST, width 2.
  - Burst counter width.
- One sub-module `tick_gen`:
  - Parameter CLK_DIV_MAX.
  - Inputs: sys_clk, sys_rst_n, hold (=pause), clr (=mode_pulse).
  - Output: tick.
- FSM and pattern registers live in the top level.

Test Plan (all with CLK_DIV_MAX=4, i.e. 5-cycle tick; LED_W=4; BURST_N=2):
- Reset then idle 50 cycles → mode_cur=0, led_out=4'b0000, tick_out pulses every 5 cycles.
- One mode_pulse → mode_cur=1 next cycle; led_out alternates 1111/0000 every 5 cycles, tick_out aligned with each change.
- Two pulses (to WATER) → led_out=0001 on entry, then 0010, 0100, 1000, 0001 at 5-cycle intervals.
- Three pulses (to BURST), run 40 ticks → led_out sequence per tick: 1111,0000,1111,0000,0000,0000,0000,0000, repeating (0000 is the value after the 8th tick of each cycle).
- In BLINK, assert pause for 12 cycles mid-period → no led_out change or tick_out during pause; the remaining count completes after release, so the period is stretched by exactly 12 cycles.
- mode_pulse in the same cycle that cnt==4 → mode advances, no pattern step, cnt=0. Async reset asserted mid-WATER → all outputs 0 immediately, mode_cur=0.
